// File: rtl/vec_ctrl_sequencer.sv
// Decode-stage control unit: combinational scalar opcode decode plus a
// two-state burst sequencer that streams a vector-register fill over
// BEATS = VLEN/LANES beats for the custom vector-load opcode.
//
// Handshake: the decode stage presents an instruction with instr_valid.
// The instruction is consumed in a cycle where instr_valid=1, stall=0 and
// busy=0. While busy=1 the front end must hold its instruction. Inputs in
// that window are ignored, and the held instruction is consumed on the
// first idle cycle.
module vec_ctrl_sequencer #(
  parameter int VLEN   = 8,
  parameter int LANES  = 2,
  parameter int ADDR_W = 32,
  localparam int BEATS = VLEN / LANES,
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall,
  output logic              branch,
  output logic              memtoreg,
  output logic              memwrite,
  output logic              aluSrc,
  output logic              regwrite,
  output logic [1:0]        aluop,
  output logic              WVRwrite,
  output logic              SVRwrite,
  output logic [CNT_W-1:0]  beat_idx,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_VLOAD  = 7'b0000010;

  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(LANES * 4);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   base_q, base_nxt;
  // cls_q = 1 selects the spike register (funct3 >= 3), 0 the weight register
  logic                cls_q, cls_nxt;
  logic                illegal_q, illegal_nxt;
  logic                decode_en;

  assign decode_en = (state == IDLE) && instr_valid && !stall;

  // State, beat counter, captured burst context and the registered illegal pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base_q    <= '0;
      cls_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      base_q    <= base_nxt;
      cls_q     <= cls_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  // Next-state logic and control-line decode; every line defaults to 0
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    base_nxt    = base_q;
    cls_nxt     = cls_q;
    illegal_nxt = 1'b0;
    branch      = 1'b0;
    memtoreg    = 1'b0;
    memwrite    = 1'b0;
    aluSrc      = 1'b0;
    regwrite    = 1'b0;
    aluop       = 2'b00;
    WVRwrite    = 1'b0;
    SVRwrite    = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        if (decode_en) begin
          case (opcode)
            OP_LOAD: begin
              aluSrc   = 1'b1;
              memtoreg = 1'b1;
              regwrite = 1'b1;
            end
            OP_STORE: begin
              aluSrc   = 1'b1;
              memwrite = 1'b1;
            end
            OP_RTYPE: begin
              regwrite = 1'b1;
              aluop    = 2'b10;
            end
            OP_BRANCH: begin
              branch = 1'b1;
              aluop  = 2'b01;
            end
            OP_ITYPE: begin
              aluSrc   = 1'b1;
              regwrite = 1'b1;
            end
            OP_VLOAD: begin
              // Accept cycle: capture context only, no control lines yet
              base_nxt  = base_addr;
              cls_nxt   = (funct3 >= 3'd3);
              cnt_nxt   = '0;
              state_nxt = BURST;
            end
            default: illegal_nxt = 1'b1;
          endcase
        end
      end

      BURST: begin
        // A stalled burst cycle freezes the counter and keeps every line low
        if (!stall) begin
          aluSrc   = 1'b1;
          memtoreg = 1'b1;
          WVRwrite = !cls_q;
          SVRwrite = cls_q;
          if (cnt == LAST_BEAT) begin
            done      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Beat position outputs; held at zero outside a burst so idle looks like reset
  always_comb begin
    busy      = (state == BURST);
    dbg_state = state;
    illegal   = illegal_q;
    beat_idx  = '0;
    beat_addr = '0;
    if (state == BURST) begin
      beat_idx  = cnt;
      beat_addr = base_q + ADDR_W'(cnt) * BEAT_BYTES;
    end
  end

endmodule

// File: tb/tb_vec_ctrl_sequencer.sv
// Directed bench for vec_ctrl_sequencer (VLEN=8, LANES=2, ADDR_W=32).
module tb_vec_ctrl_sequencer;

  localparam int VLEN   = 8;
  localparam int LANES  = 2;
  localparam int ADDR_W = 32;
  localparam int BEATS  = VLEN / LANES;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_VLOAD  = 7'b0000010;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              instr_valid = 1'b0;
  logic [6:0]        opcode = '0;
  logic [2:0]        funct3 = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              stall = 1'b0;
  logic branch, memtoreg, memwrite, aluSrc, regwrite;
  logic [1:0] aluop;
  logic WVRwrite, SVRwrite, busy, done, illegal, dbg_state;
  logic [1:0]        beat_idx;
  logic [ADDR_W-1:0] beat_addr;

  vec_ctrl_sequencer #(.VLEN(VLEN), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .base_addr(base_addr), .stall(stall),
    .branch(branch), .memtoreg(memtoreg), .memwrite(memwrite),
    .aluSrc(aluSrc), .regwrite(regwrite), .aluop(aluop),
    .WVRwrite(WVRwrite), .SVRwrite(SVRwrite), .beat_idx(beat_idx),
    .beat_addr(beat_addr), .busy(busy), .done(done), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Scalar control word {branch,memtoreg,memwrite,aluSrc,regwrite,aluop}
  function automatic logic [6:0] scalar_ctrl(input logic [6:0] op);
    case (op)
      OP_LOAD:   return 7'b0101100;
      OP_STORE:  return 7'b0011000;
      OP_RTYPE:  return 7'b0000110;
      OP_BRANCH: return 7'b1000001;
      OP_ITYPE:  return 7'b0001100;
      default:   return 7'b0000000;
    endcase
  endfunction

  function automatic logic known_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_BRANCH) || (op == OP_ITYPE) || (op == OP_VLOAD);
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  idx;
    logic        svr;
    logic        last;
  } beat_t;

  // Pending beats of the burst in flight; non-empty means busy
  beat_t exp_q[$];
  logic  ill_m = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    beat_t b;
    if (rst) begin
      exp_q.delete();
      ill_m = 1'b0;
    end else begin
      ill_m = (exp_q.size() == 0) && instr_valid && !stall && !known_op(opcode);
      if (exp_q.size() != 0) begin
        if (!stall) void'(exp_q.pop_front());
      end else if (instr_valid && !stall && opcode == OP_VLOAD) begin
        for (int i = 0; i < BEATS; i++) begin
          b.addr = base_addr + 32'(i * LANES * 4);
          b.idx  = 2'(i);
          b.svr  = (funct3 >= 3'd3);
          b.last = (i == BEATS - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  // ---------------- observation ----------------
  logic [31:0] obs_w[$];
  logic [31:0] obs_s[$];
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          rw_busy_cnt = 0;
  logic [31:0] done_addr = '0;

  task automatic clear_obs();
    obs_w.delete();
    obs_s.delete();
    busy_cnt    = 0;
    done_cnt    = 0;
    rw_busy_cnt = 0;
    done_addr   = '0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic [11:0] exp_c, act_c;
    act_c = {branch, memtoreg, memwrite, aluSrc, regwrite, aluop,
             WVRwrite, SVRwrite, done, busy, illegal};
    exp_c = '0;
    if (rst) begin
      chk("reset_ctrl", 64'(act_c), 64'(exp_c));
      chk("reset_beat", 64'({beat_idx, beat_addr}), 64'd0);
    end else begin
      exp_c[0] = ill_m;
      if (exp_q.size() != 0) begin
        exp_c[1] = 1'b1;
        if (!stall) begin
          exp_c[10] = 1'b1;
          exp_c[8]  = 1'b1;
          exp_c[4]  = !exp_q[0].svr;
          exp_c[3]  = exp_q[0].svr;
          exp_c[2]  = exp_q[0].last;
        end
        chk("ctrl", 64'(act_c), 64'(exp_c));
        chk("beat_idx", 64'(beat_idx), 64'(exp_q[0].idx));
        chk("beat_addr", 64'(beat_addr), 64'(exp_q[0].addr));
      end else begin
        if (instr_valid && !stall) exp_c[11:5] = scalar_ctrl(opcode);
        chk("ctrl", 64'(act_c), 64'(exp_c));
      end
      if (WVRwrite) obs_w.push_back(beat_addr);
      if (SVRwrite) obs_s.push_back(beat_addr);
      if (busy) busy_cnt++;
      if (busy && regwrite) rw_busy_cnt++;
      if (done) begin
        done_cnt++;
        done_addr = beat_addr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] ba, input logic st);
    instr_valid = v;
    opcode      = op;
    funct3      = f3;
    base_addr   = ba;
    stall       = st;
  endtask

  task automatic check_obs(input string nm, input logic [31:0] got[$], input logic [31:0] ex[4]);
    chk({nm, "_count"}, 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("%s_addr%0d", nm, i), 64'(got[i]), 64'(ex[i]));
      else chk($sformatf("%s_addr%0d", nm, i), 64'hdead, 64'(ex[i]));
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [31:0] ex[4];
    logic [6:0]  ops[5];
    ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_ITYPE, OP_RTYPE};

    repeat (3) cycle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_beat_addr", 64'(beat_addr), 64'd0);
    rst = 1'b0;

    // R-type literal
    drive(1, OP_RTYPE, 0, 0, 0);
    #2;
    chk("rtype_regwrite", 64'(regwrite), 64'd1);
    chk("rtype_aluop", 64'(aluop), 64'd2);
    chk("rtype_others", 64'({branch, memtoreg, memwrite, aluSrc, WVRwrite, SVRwrite, done, busy}), 64'd0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, ops[i], 3'(i), 32'h40, 0);
      cycle();
    end
    drive(1, OP_LOAD, 0, 0, 1);
    cycle();
    drive(0, OP_RTYPE, 0, 0, 0);
    cycle();

    // Illegal opcode
    drive(1, OP_BAD, 0, 0, 0);
    #2;
    chk("ill_same_cycle", 64'({branch, memtoreg, memwrite, aluSrc, regwrite, aluop, illegal}), 64'd0);
    cycle();
    drive(0, 0, 0, 0, 0);
    #2;
    chk("ill_next", 64'(illegal), 64'd1);
    cycle();
    #2;
    chk("ill_gone", 64'(illegal), 64'd0);
    cycle();

    // WVR burst, load held at the front end while busy
    clear_obs();
    drive(1, OP_VLOAD, 1, 32'h100, 0);
    cycle();
    drive(1, OP_LOAD, 0, 0, 0);
    repeat (4) cycle();
    #2;
    chk("load_after_busy", 64'({regwrite, busy}), 64'b10);
    chk("wvr_busy_cycles", 64'(busy_cnt), 64'd4);
    chk("wvr_done_cnt", 64'(done_cnt), 64'd1);
    chk("wvr_done_addr", 64'(done_addr), 64'h118);
    chk("wvr_no_svr", 64'(obs_s.size()), 64'd0);
    chk("busy_regwrite", 64'(rw_busy_cnt), 64'd0);
    ex = '{32'h100, 32'h108, 32'h110, 32'h118};
    check_obs("wvr", obs_w, ex);
    drive(0, 0, 0, 0, 0);
    cycle();

    // SVR burst with a stall on the second beat cycle
    clear_obs();
    drive(1, OP_VLOAD, 5, 32'h100, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle();
    stall = 1'b1;
    #2;
    chk("stall_idx", 64'(beat_idx), 64'd1);
    chk("stall_addr", 64'(beat_addr), 64'h108);
    chk("stall_strobe", 64'({WVRwrite, SVRwrite, aluSrc, memtoreg, done}), 64'd0);
    cycle();
    stall = 1'b0;
    repeat (4) cycle();
    chk("svr_busy_cycles", 64'(busy_cnt), 64'd5);
    chk("svr_done_cnt", 64'(done_cnt), 64'd1);
    chk("svr_no_wvr", 64'(obs_w.size()), 64'd0);
    check_obs("svr", obs_s, ex);

    // Reset in the middle of a burst
    clear_obs();
    drive(1, OP_VLOAD, 0, 32'h200, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out", 64'({WVRwrite, SVRwrite, done, aluSrc, memtoreg, beat_idx, beat_addr}), 64'd0);
    cycle();
    cycle();
    rst = 1'b0;
    chk("midrst_beats", 64'(obs_w.size()), 64'd2);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    clear_obs();
    drive(1, OP_VLOAD, 4, 32'h300, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    #2;
    chk("restart_idx", 64'(beat_idx), 64'd0);
    chk("restart_addr", 64'(beat_addr), 64'h300);
    chk("restart_svr", 64'(SVRwrite), 64'd1);
    repeat (4) cycle();
    chk("restart_done", 64'(done_cnt), 64'd1);

    // Address wrap
    clear_obs();
    drive(1, OP_VLOAD, 2, 32'hFFFF_FFF8, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    repeat (5) cycle();
    ex = '{32'hFFFF_FFF8, 32'h0, 32'h8, 32'h10};
    check_obs("wrap", obs_w, ex);

    repeat (2) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
